// File: rtl/calu_pkg.sv
// Shared constants and types for the complex-ALU result buffer.
package calu_pkg;

    // Widths of the fields that make up one buffered result.
    localparam int FLAG_W  = 12;
    localparam int Z_W     = 32;
    localparam int OPC_W   = 4;
    localparam int ENTRY_W = OPC_W + FLAG_W + Z_W;

    // Bit positions of the status flags inside the 12-bit flag vector.
    localparam int FLG_CR   = 11;
    localparam int FLG_CI   = 10;
    localparam int FLG_DVFR = 9;
    localparam int FLG_DVFI = 8;
    localparam int FLG_ZER  = 7;
    localparam int FLG_ZEI  = 6;
    localparam int FLG_ZR   = 5;
    localparam int FLG_ZI   = 4;
    localparam int FLG_OR   = 3;
    localparam int FLG_OI   = 2;
    localparam int FLG_NR   = 1;
    localparam int FLG_NI   = 0;

    // Opcodes issued by the ALU.
    localparam logic [OPC_W-1:0] OP_CADD = 4'b0000;
    localparam logic [OPC_W-1:0] OP_CSUB = 4'b0001;
    localparam logic [OPC_W-1:0] OP_CMUL = 4'b0010;
    localparam logic [OPC_W-1:0] OP_CDIV = 4'b0011;

    // Divide-overflow and divide-by-zero flags raise the error interrupt.
    localparam logic [FLAG_W-1:0] ERR_MASK =
        (12'b1 << FLG_DVFR) | (12'b1 << FLG_DVFI) |
        (12'b1 << FLG_ZER)  | (12'b1 << FLG_ZEI);

    // One buffered result; packs to {opcode, flags, z}.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [FLAG_W-1:0] flags;
        logic [Z_W-1:0]    z;
    } entry_t;

    // True when any error-class flag is set in the given vector.
    function automatic logic has_err(input logic [FLAG_W-1:0] flags);
        return |(flags & ERR_MASK);
    endfunction

endpackage

// File: rtl/calu_sync_fifo.sv
// First-word-fall-through synchronous FIFO; full/empty derive only from count.
module calu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_not_full;
    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rd_data;

    assign w_not_full  = (r_count != CW'(DEPTH));
    assign w_not_empty = (r_count != CW'(0));
    assign w_push      = i_wr_valid && w_not_full;
    assign w_pop       = w_not_empty && i_rd_ready;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents are not reset, occupancy guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Head presented combinationally; forced to zero while empty.
    always_comb begin
        w_rd_data = '0;
        if (w_not_empty) begin
            w_rd_data = r_mem[r_rd_ptr];
        end else begin
            w_rd_data = '0;
        end
    end

    assign o_wr_ready = w_not_full;
    assign o_rd_valid = w_not_empty;
    assign o_rd_data  = w_rd_data;
    assign o_count    = r_count;

endmodule

// File: rtl/calu_result_buffer.sv
// Result buffer between the complex ALU and writeback: FIFO, sticky status,
// error interrupt and a saturating stall counter.
module calu_result_buffer
    import calu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Z_W-1:0]          in_z,
    input  logic [FLAG_W-1:0]       in_flags,
    input  logic [OPC_W-1:0]        in_opcode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Z_W-1:0]          out_z,
    output logic [FLAG_W-1:0]       out_flags,
    output logic [OPC_W-1:0]        out_opcode,
    output logic [$clog2(DEPTH):0]  count,
    output logic [FLAG_W-1:0]       sticky_flags,
    input  logic                    sticky_clr,
    output logic                    err_irq,
    output logic [CNT_W-1:0]        stall_cnt,
    input  logic                    stall_clr
);

    entry_t            w_wr_entry;
    entry_t            w_rd_entry;
    logic [ENTRY_W-1:0] w_rd_bits;
    logic              w_in_ready;
    logic              w_push;
    logic              w_stall;
    logic [FLAG_W-1:0] w_sticky_nxt;

    logic [FLAG_W-1:0] r_sticky;
    logic              r_err_irq;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_wr_entry = '{opcode: in_opcode, flags: in_flags, z: in_z};

    calu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_valid (in_valid),
        .o_wr_ready (w_in_ready),
        .i_wr_data  (w_wr_entry),
        .o_rd_valid (out_valid),
        .i_rd_ready (out_ready),
        .o_rd_data  (w_rd_bits),
        .o_count    (count)
    );

    assign w_rd_entry = entry_t'(w_rd_bits);
    assign in_ready   = w_in_ready;
    assign out_z      = w_rd_entry.z;
    assign out_flags  = w_rd_entry.flags;
    assign out_opcode = w_rd_entry.opcode;

    assign w_push  = in_valid && w_in_ready;
    assign w_stall = in_valid && !w_in_ready;

    // Sticky next state: a clear wins over history but not over a same-cycle push.
    always_comb begin
        w_sticky_nxt = r_sticky;
        if (sticky_clr) begin
            w_sticky_nxt = w_push ? in_flags : '0;
        end else if (w_push) begin
            w_sticky_nxt = r_sticky | in_flags;
        end else begin
            w_sticky_nxt = r_sticky;
        end
    end

    // Sticky register and error interrupt, the latter derived from the next sticky value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky  <= '0;
            r_err_irq <= 1'b0;
        end else begin
            r_sticky  <= w_sticky_nxt;
            r_err_irq <= has_err(w_sticky_nxt);
        end
    end

    // Saturating stall counter; clear takes priority over a concurrent stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign sticky_flags = r_sticky;
    assign err_irq      = r_err_irq;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_calu_result_buffer.sv
// Self-checking bench for calu_result_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_calu_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_z;
    logic [11:0] in_flags;
    logic [3:0]  in_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [11:0] out_flags;
    logic [3:0]  out_opcode;
    logic [2:0]  count;
    logic [11:0] sticky_flags;
    logic        sticky_clr;
    logic        err_irq;
    logic [3:0]  stall_cnt;
    logic        stall_clr;

    calu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_z         (in_z),
        .in_flags     (in_flags),
        .in_opcode    (in_opcode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_flags    (out_flags),
        .out_opcode   (out_opcode),
        .count        (count),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .err_irq      (err_irq),
        .stall_cnt    (stall_cnt),
        .stall_clr    (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [47:0] mq[$];
    logic [11:0] m_sticky;
    logic        m_err;
    int          m_stall;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sticky = 12'h000;
        m_err    = 1'b0;
        m_stall  = 0;
    endtask

    // Compare every output with the model, then advance one clock and update the model.
    task automatic cycle();
        logic [47:0] head;
        bit push, pop, stall;
        vectors++;
        head = (mq.size() != 0) ? mq[0] : 48'd0;
        chk("out_valid", 48'(out_valid), 48'(mq.size() != 0));
        chk("in_ready", 48'(in_ready), 48'(mq.size() < DEPTH));
        chk("count", 48'(count), 48'(mq.size()));
        chk("out_z", 48'(out_z), 48'(head[31:0]));
        chk("out_flags", 48'(out_flags), 48'(head[43:32]));
        chk("out_opcode", 48'(out_opcode), 48'(head[47:44]));
        chk("sticky", 48'(sticky_flags), 48'(m_sticky));
        chk("err_irq", 48'(err_irq), 48'(m_err));
        chk("stall_cnt", 48'(stall_cnt), 48'(m_stall));
        push  = in_valid && (mq.size() < DEPTH);
        stall = in_valid && (mq.size() >= DEPTH);
        pop   = out_ready && (mq.size() != 0);
        @(posedge clk);
        if (pop) mq.delete(0);
        if (push) mq.push_back({in_opcode, in_flags, in_z});
        if (sticky_clr) m_sticky = push ? in_flags : 12'h000;
        else if (push)  m_sticky = m_sticky | in_flags;
        m_err = (m_sticky & 12'h3C0) != 12'h000;
        if (stall_clr)                  m_stall = 0;
        else if (stall && m_stall < SAT) m_stall++;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0; stall_clr = 1'b0;
        in_z = $urandom; in_flags = 12'($urandom); in_opcode = 4'($urandom);
    endtask

    task automatic push_one(input logic [31:0] z, input logic [11:0] f, input logic [3:0] op);
        in_valid = 1'b1; in_z = z; in_flags = f; in_opcode = op;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && out_valid; i++) cycle();
        chk("drain_empty", 48'(out_valid), 48'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rst_count", 48'(count), 48'd0);

        // First push visible the next cycle.
        push_one(32'h0003_0004, 12'h000, 4'b0000);
        chk("first_z", 48'(out_z), 48'h0003_0004);
        chk("first_valid", 48'(out_valid), 48'd1);
        chk("first_count", 48'(count), 48'd1);
        drain();

        // Fill, stall three cycles, then pop in order.
        for (int i = 1; i <= 4; i++) push_one(32'(i), 12'h000, 4'b0001);
        chk("full_ready", 48'(in_ready), 48'd0);
        in_valid = 1'b1; in_z = 32'hDEAD_BEEF;
        repeat (3) cycle();
        in_valid = 1'b0;
        chk("stall3", 48'(stall_cnt), 48'd3);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("pop_order", 48'(out_z), 48'(i));
            cycle();
        end
        out_ready = 1'b0;
        chk("empty_after_pop", 48'(count), 48'd0);

        // Simultaneous push and pop at count 2.
        push_one(32'd10, 12'h000, 4'b0010);
        push_one(32'd11, 12'h000, 4'b0010);
        in_valid = 1'b1; in_z = 32'd5; out_ready = 1'b1;
        chk("pp_head", 48'(out_z), 48'd10);
        cycle();
        idle();
        chk("pp_count", 48'(count), 48'd2);
        chk("pp_newhead", 48'(out_z), 48'd11);
        drain();

        // Error flag sets err_irq; clear with concurrent push.
        push_one(32'd7, 12'h200, 4'b0011);
        chk("irq_set", 48'(err_irq), 48'd1);
        chk("sticky_200", 48'(sticky_flags), 48'h200);
        sticky_clr = 1'b1;
        push_one(32'd8, 12'h001, 4'b0011);
        sticky_clr = 1'b0;
        chk("sticky_001", 48'(sticky_flags), 48'h001);
        chk("irq_clr", 48'(err_irq), 48'd0);
        drain();

        // Saturation and clear priority.
        stall_clr = 1'b1; cycle(); stall_clr = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'(100 + i), 12'h000, 4'b0000);
        in_valid = 1'b1;
        repeat (20) cycle();
        chk("sat15", 48'(stall_cnt), 48'd15);
        stall_clr = 1'b1; cycle(); stall_clr = 1'b0;
        chk("clr0", 48'(stall_cnt), 48'd0);
        cycle();
        chk("clr1", 48'(stall_cnt), 48'd1);
        idle();
        drain();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_z       = $urandom;
            in_flags   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : (12'($urandom) & 12'hC3F);
            in_opcode  = 4'($urandom);
            sticky_clr = ($urandom_range(0, 15) == 0);
            stall_clr  = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle();
        drain();

        // Reset mid-stream with three entries held.
        for (int i = 0; i < 3; i++) push_one(32'(200 + i), 12'h3C0, 4'b0001);
        chk("pre_rst_count", 48'(count), 48'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 48'(out_valid), 48'd0);
        chk("rst_cnt", 48'(count), 48'd0);
        chk("rst_sticky", 48'(sticky_flags), 48'd0);
        chk("rst_irq", 48'(err_irq), 48'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        push_one(32'hABCD_1234, 12'h5A5, 4'b0011);
        chk("post_rst_z", 48'(out_z), 48'hABCD_1234);
        chk("post_rst_flags", 48'(out_flags), 48'h5A5);
        chk("post_rst_op", 48'(out_opcode), 48'h3);
        chk("post_rst_count", 48'(count), 48'd1);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
